// File: rtl/ddr2_local_arbiter.sv
// Two-port round-robin arbiter in front of the DDR2 controller local interface, with read-return steering.
// Optional DDR2_ARB_PERF_EN adds per-port command counters and a read-tag high-water mark.
module ddr2_local_arbiter #(
   parameter int unsigned ADDR_W  = 25,
   parameter int unsigned DATA_W  = 32,
   parameter int unsigned BE_W    = 4,
   parameter int unsigned SIZE_W  = 3,
   parameter int unsigned RD_TAGS = 8
) (
   input  logic                phy_clk,
   input  logic                reset_phy_clk_n,
   input  logic                local_init_done,
   input  logic [ADDR_W-1:0]   p0_address,
   input  logic [SIZE_W-1:0]   p0_size,
   input  logic [BE_W-1:0]     p0_be,
   input  logic [DATA_W-1:0]   p0_wdata,
   input  logic                p0_read_req,
   input  logic                p0_write_req,
   input  logic                p0_burstbegin,
   output logic                p0_ready,
   output logic [DATA_W-1:0]   p0_rdata,
   output logic                p0_rdata_valid,
   input  logic [ADDR_W-1:0]   p1_address,
   input  logic [SIZE_W-1:0]   p1_size,
   input  logic [BE_W-1:0]     p1_be,
   input  logic [DATA_W-1:0]   p1_wdata,
   input  logic                p1_read_req,
   input  logic                p1_write_req,
   input  logic                p1_burstbegin,
   output logic                p1_ready,
   output logic [DATA_W-1:0]   p1_rdata,
   output logic                p1_rdata_valid,
   output logic [ADDR_W-1:0]   local_address,
   output logic [SIZE_W-1:0]   local_size,
   output logic [BE_W-1:0]     local_be,
   output logic [DATA_W-1:0]   local_wdata,
   output logic                local_read_req,
   output logic                local_write_req,
   output logic                local_burstbegin,
   input  logic                local_ready,
   input  logic [DATA_W-1:0]   local_rdata,
   input  logic                local_rdata_valid,
`ifdef DDR2_ARB_PERF_EN
   output logic [31:0]         p0_cmd_count,
   output logic [31:0]         p1_cmd_count,
   output logic [$clog2(RD_TAGS):0] rd_tags_max,
`endif
   output logic                arb_error
);

   localparam int unsigned PTR_W = $clog2(RD_TAGS);
   localparam int unsigned CNT_W = PTR_W + 1;

   typedef enum logic [0:0] {S_IDLE = 1'b0, S_WBURST = 1'b1} state_t;

   state_t              r_state;
   state_t              w_state_nxt;
   logic                r_run;
   logic                r_rr;
   logic                r_lock;
   logic [SIZE_W-1:0]   r_wcnt;
   logic [PTR_W-1:0]    r_wptr;
   logic [PTR_W-1:0]    r_rptr;
   logic [CNT_W-1:0]    r_cnt;
   logic [CNT_W-1:0]    w_cnt_nxt;
   logic [SIZE_W-1:0]   r_rcnt;
   logic                r_err;
   logic [DATA_W-1:0]   r_p0_rdata;
   logic [DATA_W-1:0]   r_p1_rdata;
   logic                r_tag_port [RD_TAGS];
   logic [SIZE_W-1:0]   r_tag_size [RD_TAGS];

   logic                w_en;
   logic                w_full;
   logic                w_empty;
   logic                w_rd0;
   logic                w_rd1;
   logic                w_elig0;
   logic                w_elig1;
   logic                w_gnt_vld;
   logic                w_gnt;
   logic                w_sel_wr;
   logic                w_sel_rd;
   logic [SIZE_W-1:0]   w_sel_size;
   logic [SIZE_W-1:0]   w_size_eff;
   logic                w_acc_rd;
   logic                w_acc_wr;
   logic                w_head_port;
   logic [SIZE_W-1:0]   w_head_size;
   logic [SIZE_W-1:0]   w_rcnt_inc;
   logic                w_ret;
   logic                w_pop;
   logic                w_push;

   // r_run keeps the command path dark until the first clock after reset release
   assign w_en    = r_run & local_init_done;
   assign w_full  = (r_cnt == CNT_W'(RD_TAGS));
   assign w_empty = (r_cnt == '0);
   assign w_rd0   = p0_read_req & ~p0_write_req & ~w_full;
   assign w_rd1   = p1_read_req & ~p1_write_req & ~w_full;
   assign w_elig0 = p0_write_req | w_rd0;
   assign w_elig1 = p1_write_req | w_rd1;

   always_ff @(posedge phy_clk or negedge reset_phy_clk_n) begin
      if (!reset_phy_clk_n) r_state <= S_IDLE;
      else                  r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      unique case (r_state)
         S_IDLE:   if (w_acc_wr && w_size_eff != SIZE_W'(1)) w_state_nxt = S_WBURST;
         S_WBURST: if (w_acc_wr && r_wcnt == SIZE_W'(1))     w_state_nxt = S_IDLE;
         default:  w_state_nxt = S_IDLE;
      endcase
   end

   // grant selection: free round-robin in IDLE, locked port during a write burst
   always_comb begin
      w_gnt_vld = 1'b0;
      w_gnt     = 1'b0;
      unique case (r_state)
         S_IDLE: begin
            if (w_en && (w_elig0 || w_elig1)) begin
               w_gnt_vld = 1'b1;
               w_gnt     = (w_elig0 && w_elig1) ? r_rr : w_elig1;
            end
         end
         S_WBURST: begin
            if (w_en) begin
               w_gnt_vld = 1'b1;
               w_gnt     = r_lock;
            end
         end
         default: ;
      endcase
   end

   assign w_sel_wr   = w_gnt ? p1_write_req : p0_write_req;
   assign w_sel_rd   = (r_state == S_IDLE) & (w_gnt ? w_rd1 : w_rd0);
   assign w_sel_size = w_gnt ? p1_size : p0_size;
   assign w_size_eff = (w_sel_size == '0) ? SIZE_W'(1) : w_sel_size;

   assign local_write_req  = w_gnt_vld & w_sel_wr;
   assign local_read_req   = w_gnt_vld & w_sel_rd;
   assign local_burstbegin = w_gnt_vld & (w_gnt ? p1_burstbegin : p0_burstbegin);
   assign local_address    = w_gnt_vld ? (w_gnt ? p1_address : p0_address) : '0;
   assign local_size       = w_gnt_vld ? w_sel_size : '0;
   assign local_be         = w_gnt_vld ? (w_gnt ? p1_be : p0_be) : '0;
   assign local_wdata      = w_gnt_vld ? (w_gnt ? p1_wdata : p0_wdata) : '0;
   assign p0_ready         = w_gnt_vld & ~w_gnt & local_ready;
   assign p1_ready         = w_gnt_vld &  w_gnt & local_ready;

   assign w_acc_rd = local_ready & local_read_req;
   assign w_acc_wr = local_ready & local_write_req;

   always_ff @(posedge phy_clk or negedge reset_phy_clk_n) begin
      if (!reset_phy_clk_n) begin
         r_run  <= 1'b0;
         r_rr   <= 1'b0;
         r_lock <= 1'b0;
         r_wcnt <= '0;
      end else begin
         r_run <= 1'b1;
         if (r_state == S_IDLE) begin
            if (w_acc_rd) begin
               r_rr <= ~w_gnt;
            end else if (w_acc_wr) begin
               if (w_size_eff == SIZE_W'(1)) begin
                  r_rr <= ~w_gnt;
               end else begin
                  r_lock <= w_gnt;
                  r_wcnt <= w_size_eff - SIZE_W'(1);
               end
            end
         end else if (w_acc_wr) begin
            r_wcnt <= r_wcnt - SIZE_W'(1);
            if (r_wcnt == SIZE_W'(1)) r_rr <= ~r_lock;
         end
      end
   end

   // outstanding-read tag FIFO; head entry steers returning beats
   assign w_head_port = r_tag_port[r_rptr];
   assign w_head_size = r_tag_size[r_rptr];
   assign w_rcnt_inc  = r_rcnt + SIZE_W'(1);
   assign w_ret       = local_rdata_valid & ~w_empty;
   assign w_pop       = w_ret & (w_rcnt_inc == w_head_size);
   assign w_push      = w_acc_rd;

   always_comb begin
      w_cnt_nxt = r_cnt;
      unique case ({w_push, w_pop})
         2'b10:   w_cnt_nxt = r_cnt + CNT_W'(1);
         2'b01:   w_cnt_nxt = r_cnt - CNT_W'(1);
         default: w_cnt_nxt = r_cnt;
      endcase
   end

   always_ff @(posedge phy_clk) begin
      if (w_push) begin
         r_tag_port[r_wptr] <= w_gnt;
         r_tag_size[r_wptr] <= w_size_eff;
      end
   end

   always_ff @(posedge phy_clk or negedge reset_phy_clk_n) begin
      if (!reset_phy_clk_n) begin
         r_wptr     <= '0;
         r_rptr     <= '0;
         r_cnt      <= '0;
         r_rcnt     <= '0;
         r_err      <= 1'b0;
         r_p0_rdata <= '0;
         r_p1_rdata <= '0;
      end else begin
         r_cnt <= w_cnt_nxt;
         if (w_push) r_wptr <= r_wptr + PTR_W'(1);
         if (w_pop) begin
            r_rptr <= r_rptr + PTR_W'(1);
            r_rcnt <= '0;
         end else if (w_ret) begin
            r_rcnt <= w_rcnt_inc;
         end
         if (local_rdata_valid && w_empty) r_err <= 1'b1;
         if (w_ret && !w_head_port) r_p0_rdata <= local_rdata;
         if (w_ret &&  w_head_port) r_p1_rdata <= local_rdata;
      end
   end

   assign p0_rdata_valid = w_ret & ~w_head_port;
   assign p1_rdata_valid = w_ret &  w_head_port;
   assign p0_rdata       = p0_rdata_valid ? local_rdata : r_p0_rdata;
   assign p1_rdata       = p1_rdata_valid ? local_rdata : r_p1_rdata;
   assign arb_error      = r_err;

`ifdef DDR2_ARB_PERF_EN
   logic [31:0]      r_p0_cmd_count;
   logic [31:0]      r_p1_cmd_count;
   logic [CNT_W-1:0] r_tags_max;
   logic             w_cmd_acc;

   // a command is a read accept or the first beat of a write
   assign w_cmd_acc = w_acc_rd | (w_acc_wr & (r_state == S_IDLE));

   always_ff @(posedge phy_clk or negedge reset_phy_clk_n) begin
      if (!reset_phy_clk_n) begin
         r_p0_cmd_count <= '0;
         r_p1_cmd_count <= '0;
         r_tags_max     <= '0;
      end else begin
         if (w_cmd_acc && !w_gnt) r_p0_cmd_count <= r_p0_cmd_count + 32'd1;
         if (w_cmd_acc &&  w_gnt) r_p1_cmd_count <= r_p1_cmd_count + 32'd1;
         if (w_cnt_nxt > r_tags_max) r_tags_max <= w_cnt_nxt;
      end
   end

   assign p0_cmd_count = r_p0_cmd_count;
   assign p1_cmd_count = r_p1_cmd_count;
   assign rd_tags_max  = r_tags_max;
`endif

endmodule

// File: doc/ddr2_local_arbiter.md
Name: ddr2_local_arbiter

Overview:
- Two-requester arbiter that shares the DDR2 controller's single local (Avalon-style) command/data interface between port 0 and port 1.
- Sits between user masters (e.g. RAM tester, host DMA) and the controller/PHY wrapper; runs on phy_clk.
- Round-robin grant between the ports, with write bursts locked until their last beat.
- Keeps a tag FIFO of outstanding reads so that returning local_rdata beats are steered to the port that issued them.

Parameters:
ADDR_W, 25, local address width
DATA_W, 32, local data width
BE_W, 4, byte-enable width (DATA_W/8)
SIZE_W, 3, burst-size width
RD_TAGS, 8, depth of the outstanding-read tag FIFO (power of 2, >=2)

Ports:
phy_clk  in  1  controller half-rate clock; all logic is on its rising edge
reset_phy_clk_n  in  1  asynchronous active-low reset
local_init_done  in  1  controller calibration complete
pN_address / pN_size / pN_be / pN_wdata  in  ADDR_W/SIZE_W/BE_W/DATA_W  port N (N=0,1) command fields
pN_read_req / pN_write_req / pN_burstbegin  in  1  port N request strobes
pN_ready  out  1  port N command/beat accepted this cycle
pN_rdata  out  DATA_W  port N read data
pN_rdata_valid  out  1  port N read beat valid
local_address / local_size / local_be / local_wdata  out  ADDR_W/SIZE_W/BE_W/DATA_W  to controller
local_read_req / local_write_req / local_burstbegin  out  1  to controller
local_ready  in  1  controller accept
local_rdata  in  DATA_W  controller read data
local_rdata_valid  in  1  controller read beat valid
arb_error  out  1  sticky protocol-error flag

Behaviour:
- Reset: state=IDLE; rr pointer favours port 0; tag FIFO empty; beat counters 0; arb_error=0.
- Reset: all outputs 0, including the local_* command outputs and both pN_ready.
- While local_init_done=0: no grant; local_*_req=0; pN_ready=0.
- Eligibility: a port is eligible if it has write_req, or read_req with the tag FIFO not full.
- IDLE grant: the winner is chosen combinationally in the same cycle (zero-latency mux).
  - Only one port eligible: that port wins.
  - Both eligible: the port indicated by the rr pointer wins.
- Command path: the winner's fields and strobes drive local_*.
  - pN_ready = local_ready when N is the winner, 0 for the loser.
  - The losing port's fields are never forwarded.
- Accepted command: a cycle with local_ready=1 and req=1. The effective size is pN_size, with 0 treated as 1.
- Read accept: push {port, size} into the tag FIFO; rr pointer moves to the other port; stay IDLE.
- Write accept, size 1: rr pointer moves to the other port; stay IDLE.
- Write accept, size>1: go to WBURST with wcnt=size-1 and the grant locked on that port.
- WBURST: only the locked port is muxed; its read_req is ignored.
  - Each accepted write beat decrements wcnt.
  - When the beat that brings wcnt to 0 is accepted: go to IDLE and move the rr pointer to the other port.
  - If the locked port drops write_req, the controller simply stalls; the grant is held and no timeout applies.
- Read return: the tag at the FIFO head selects the destination.
  - local_rdata is routed to pN_rdata of the head port, and local_rdata_valid drives only that port's pN_rdata_valid.
  - pN_rdata of the other port holds its previous value.
  - rcnt counts returned beats; on beat == tag size, pop the head and clear rcnt.
  - Return is pass-through: 0 cycles of latency.
- Simultaneous push and pop of the tag FIFO is legal; the occupancy is unchanged.
- Full FIFO: reads are not eligible, but writes still proceed. Reads are re-eligible in the cycle after a pop.
- local_rdata_valid with the tag FIFO empty: data is dropped, both pN_rdata_valid stay 0, and arb_error is set.
- arb_error is sticky until reset.
- Asynchronous reset mid-burst or mid-return clears all state immediately; the pending tags are discarded.

Optional Feature:
DDR2_ARB_PERF_EN
- Defined: adds outputs p0_cmd_count and p1_cmd_count, 32 bits each.
  - Each increments by 1 per accepted read command or per accepted first write beat.
  - Wraps at 2^32-1 to 0; reset to 0.
  - Adds output rd_tags_max (clog2(RD_TAGS)+1 bits): the high-water mark of FIFO occupancy.
- Undefined: these ports and their logic are absent; all other behaviour is identical.

Test Plan:
- Both ports read_req continuously, size=1, local_ready=1, 6 cycles -> grants alternate p0,p1,p0,p1,p0,p1; each port gets 3 pN_ready pulses.
- p0 write size=4 and p1 read together -> p0 holds the grant for 4 accepted beats with p1_ready=0 throughout; p1 read is accepted on the next cycle.
- p0 read size=2, then p1 read size=1; controller returns beats A,B,C -> p0_rdata_valid on A,B; p1_rdata_valid on C; FIFO empty afterwards.
- Issue RD_TAGS=8 reads with no data returned -> 9th read gets no ready; a concurrent p1 write is still accepted; one return pop -> read accepted on the next cycle.
- local_rdata_valid=1 with no outstanding reads -> arb_error=1, no pN_rdata_valid; stays set until reset_phy_clk_n=0.
- Reset asserted during WBURST with wcnt=2 -> all outputs 0 immediately; after release, the first grant goes to p0 when both ports request.
